hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

- Central hazard controller for the 5-stage pipeline.
- Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register-destination fields.
- Drives the 2-bit select inputs of the two EX-stage 3:1 ALU operand muxes, and detects load-use hazards to stall IF/ID.
- Gives branch flush priority over stalling and keeps a saturating stall-cycle counter for performance analysis.

## Interface
- Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width
- Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_id  in  1  ID stage holds a real instruction
- rs1_id, rs2_id  in  REG_AW  source registers of the instruction in ID
- use_rs1_id, use_rs2_id  in  1  instruction actually reads rs1/rs2
- rd_id  in  REG_AW  destination register of the instruction in ID
- regwrite_id  in  1  instruction writes rd
- memread_id  in  1  instruction is a load
- branch_taken_ex  in  1  branch/jump resolved taken in EX this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 register file, 01 MEM/WB writeback value, 10 EX/MEM ALU result; 11 never driven
- stall_if, stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX on next edge
- flush_ifid  out  1  clear IF/ID on next edge
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow pipeline stages:
  - Entries: ex, mem, wb.
  - Fields per entry: rs1, rs2, use_rs1, use_rs2, rd, regwrite, memread.
  - An entry is a bubble when regwrite=0, memread=0 and use_rs*=0.
- Each clock edge:
  - wb <= mem
  - mem <= ex
  - ex <= ID fields, or a bubble when any of these holds: bubble_ex, valid_id=0, branch_taken_ex.
- Operand forwarding:
  - Computed combinationally from the ex entry, separately for A (rs1) and B (rs2).
  - Select 10: mem.regwrite, mem.rd!=0, mem.rd==ex.rs, and use_rs set.
  - Otherwise select 01: the same conditions evaluated against wb.
  - Otherwise select 00.
  - EX/MEM always wins over MEM/WB when both match.
- Load-use hazard, `lu`, is true when all of the following hold:
  - ex.memread and ex.rd!=0;
  - valid_id;
  - (use_rs1_id and rs1_id==ex.rd) or (use_rs2_id and rs2_id==ex.rd).
- Branch flush:
  - flush_ifid = branch_taken_ex.
  - A flush suppresses the stall.
  - stall_if = stall_id = lu & ~branch_taken_ex.
  - bubble_ex = stall_id | branch_taken_ex.
- stall_count:
  - Increments on every edge where stall_id=1.
  - Saturates at all-ones and does not wrap.
- Register x0:
  - Never a forwarding or hazard source.
  - Writes to x0 are tracked but ignored in all comparisons.

## Timing
- Reset state, asynchronous while rst_n=0:
  - All shadow entries are bubbles with rd=0.
  - fwd_a_sel = fwd_b_sel = 00.
  - stall_if = stall_id = bubble_ex = flush_ifid = 0.
  - stall_count = 0.
- Deassertion is synchronised externally. The first edge after release loads ex normally.
- All outputs except stall_count are combinational from the registered state plus the current ID/EX-stage inputs, with zero-cycle latency.
- Load-use stall lasts exactly 1 cycle. The instruction after that stall sees the load in wb and gets select 01.
- Reset asserted mid-stall clears everything immediately. No stall persists after reset.
- If branch_taken_ex and lu coincide:
  - flush_ifid=1, bubble_ex=1, stall_*=0;
  - stall_count is unchanged.

## Configuration
- Macro: HAZARD_FWD_EN.
- Defined:
  - Forwarding is active as described above.
  - Stalls occur only on load-use hazards.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - stall_id is asserted whenever an ID source matches the rd of a writing entry in ex or mem (rd!=0, no flush).
  - wb is not checked, because the register file writes before it reads.
  - A RAW dependency on the immediately preceding instruction costs 2 stall cycles.

## Test plan
- Back-to-back ALU forward: sequence `add x5,x1,x2` then `sub x6,x5,x3`. When sub is in EX, fwd_a_sel=10 and fwd_b_sel=00.
- Distance-2 forward and priority:
  - `add x5`; `add x7`; `or x8,x5,x7`: when `or` is in EX, fwd_a=01 and fwd_b=10.
  - Two writes to x5 back-to-back, then a reader of x5: the reader gets 10.
- Load-use hazard: `lw x4` followed by `add x9,x4,x4`.
  - One cycle with stall_if=stall_id=bubble_ex=1; stall_count goes 0->1.
  - Next cycle, the add is in EX with fwd_a=fwd_b=01.
- x0 and unused operands:
  - `addi x0` followed by a reader of x0: selects stay 00.
  - `lw x4` then `lui x4` (use_rs=0): no stall.
- Flush versus stall: branch_taken_ex=1 in the same cycle as a load-use match.
  - flush_ifid=1, bubble_ex=1, stall_*=0, stall_count unchanged.
  - Next cycle, ex is a bubble.
- Reset and saturation:
  - Assert rst_n=0 mid-stall: all outputs return to 0 asynchronously.
  - Hold a load-use stall for 2^CNT_W+3 cycles through forced inputs: stall_count holds at 0xFFFF.
  - Build with HAZARD_FWD_EN undefined: a back-to-back RAW dependency gives exactly 2 stall cycles and selects stay 00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_forward_unit                                          |
// | Description : Central hazard controller for a 5-stage pipeline. Keeps a    |
// |               shadow copy of the ID/EX, EX/MEM and MEM/WB destination      |
// |               fields, drives the EX-stage ALU operand forwarding selects,  |
// |               detects load-use hazards (stalling IF/ID), gives branch      |
// |               flush priority over stalls, and counts stall cycles with a   |
// |               saturating counter.                                          |
// | Macro       : HAZARD_FWD_EN - defined: forwarding active, stall only on    |
// |               load-use. Undefined: selects tied to 00, stall on any RAW    |
// |               match against a writing entry in ex or mem.                  |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               valid_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id,     |
// |               regwrite_id, memread_id        - ID-stage instruction fields |
// |               branch_taken_ex                - taken branch resolved in EX |
// |               fwd_a_sel, fwd_b_sel           - 00 RF, 01 MEM/WB, 10 EX/MEM |
// |               stall_if, stall_id, bubble_ex, flush_ifid - pipeline control |
// |               stall_count                    - saturating stall counter    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              regwrite_id,
  input  logic              memread_id,
  input  logic              branch_taken_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } entry_t;

  localparam entry_t c_bubble = '0;

  entry_t           ex_q, mem_q, wb_q;
  entry_t           ex_d, w_id_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_br;
  logic             w_lu;
  logic             w_hz;
  logic             w_stall;

  // A source is satisfied by an entry when the entry writes a non-x0 register
  // that the consumer actually reads.
  function automatic logic src_hit(input logic              use_rs,
                                   input logic [REG_AW-1:0] rs,
                                   input entry_t            e);
    return use_rs && e.regwrite && (e.rd != '0) && (e.rd == rs);
  endfunction

  // Branch is qualified by reset so no control output can assert while the
  // unit is held in reset.
  assign w_br = branch_taken_ex & rst_n;

  assign w_lu = ex_q.memread && (ex_q.rd != '0) && valid_id &&
                ((use_rs1_id && (rs1_id == ex_q.rd)) ||
                 (use_rs2_id && (rs2_id == ex_q.rd)));

`ifdef HAZARD_FWD_EN
  // EX/MEM is checked first so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic              use_rs,
                                         input logic [REG_AW-1:0] rs,
                                         input entry_t            m,
                                         input entry_t            w);
    if (src_hit(use_rs, rs, m)) return 2'b10;
    if (src_hit(use_rs, rs, w)) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_sel = fwd_sel(ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
  assign fwd_b_sel = fwd_sel(ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
  assign w_hz      = w_lu;
`else
  // Without forwarding, a reader waits until its producer reaches wb; the
  // register file writes before it reads, so wb itself never stalls.
  logic w_raw;
  assign w_raw = valid_id &&
                 (src_hit(use_rs1_id, rs1_id, ex_q)  ||
                  src_hit(use_rs1_id, rs1_id, mem_q) ||
                  src_hit(use_rs2_id, rs2_id, ex_q)  ||
                  src_hit(use_rs2_id, rs2_id, mem_q));

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
  assign w_hz      = w_lu | w_raw;
`endif

  // A flush discards the ID instruction anyway, so it overrides any stall.
  assign w_stall    = w_hz & ~w_br;
  assign stall_if   = w_stall;
  assign stall_id   = w_stall;
  assign bubble_ex  = w_stall | w_br;
  assign flush_ifid = w_br;
  assign stall_count = cnt_q;

  always_comb begin
    w_id_entry          = c_bubble;
    w_id_entry.rs1      = rs1_id;
    w_id_entry.rs2      = rs2_id;
    w_id_entry.use_rs1  = use_rs1_id;
    w_id_entry.use_rs2  = use_rs2_id;
    w_id_entry.rd       = rd_id;
    w_id_entry.regwrite = regwrite_id;
    w_id_entry.memread  = memread_id;
  end

  always_comb begin
    ex_d = c_bubble;
    if (valid_id && !bubble_ex) ex_d = w_id_entry;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= c_bubble;
      mem_q <= c_bubble;
      wb_q  <= c_bubble;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  // Not every shadow field feeds a comparison in every build; they are kept
  // so the shadow entries stay a faithful copy of the pipeline registers.
  logic unused_fields;
  assign unused_fields = ^{ex_q, mem_q, wb_q};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_forward_unit                                       |
// | Description : Self-checking bench for hazard_forward_unit. Each scenario   |
// |               task builds a table of ID-stage stimulus rows and expected   |
// |               outputs, pushes the expectation when a row is driven and     |
// |               pops/compares it mid-cycle. Expectations follow the build    |
// |               (HAZARD_FWD_EN defined or not).                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        si;
    logic        sd;
    logic        bx;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        use_rs1_id, use_rs2_id, regwrite_id, memread_id, branch_taken_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if, stall_id, bubble_ex, flush_ifid;
  logic [15:0] stall_count;

  logic [1:0]  s_fa, s_fb;
  logic        s_si, s_sd, s_bx, s_fl;
  logic [2:0]  s_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb[$];
  logic [5:0] sat_q[$];
  stim_t rows_s[$];
  exp_t  rows_e[$];

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_id(rd_id), .regwrite_id(regwrite_id), .memread_id(memread_id),
    .branch_taken_ex(branch_taken_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_ifid(flush_ifid), .stall_count(stall_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  hazard_forward_unit #(.REG_AW(5), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_id(rd_id), .regwrite_id(regwrite_id), .memread_id(memread_id),
    .branch_taken_ex(branch_taken_ex),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall_if(s_si), .stall_id(s_sd),
    .bubble_ex(s_bx), .flush_ifid(s_fl), .stall_count(s_cnt)
  );

  // ---------------- stimulus / expectation builders ----------------
  function automatic stim_t S(input int v, input int rs1, input int u1, input int rs2,
                              input int u2, input int rd, input int rw, input int mr,
                              input int br);
    stim_t s;
    s.v = 1'(v); s.rs1 = 5'(rs1); s.u1 = 1'(u1); s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.rd = 5'(rd); s.rw = 1'(rw); s.mr = 1'(mr); s.br = 1'(br);
    return s;
  endfunction

  function automatic stim_t ADD(input int rd, input int rs1, input int rs2);
    return S(1, rs1, 1, rs2, 1, rd, 1, 0, 0);
  endfunction

  function automatic stim_t LW(input int rd, input int rs1);
    return S(1, rs1, 1, 0, 0, rd, 1, 1, 0);
  endfunction

  function automatic stim_t NOP();
    return S(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t E(input int fa, input int fb, input int st, input int bx,
                             input int fl, input int cnt);
    exp_t e;
    e.fa = 2'(fa); e.fb = 2'(fb); e.si = 1'(st); e.sd = 1'(st);
    e.bx = 1'(bx); e.fl = 1'(fl); e.cnt = 16'(cnt);
    return e;
  endfunction

  function automatic exp_t obs_now();
    return {fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex, flush_ifid, stall_count};
  endfunction

  task automatic drive(input stim_t s);
    valid_id = s.v; rs1_id = s.rs1; use_rs1_id = s.u1; rs2_id = s.rs2; use_rs2_id = s.u2;
    rd_id = s.rd; regwrite_id = s.rw; memread_id = s.mr; branch_taken_ex = s.br;
  endtask

  task automatic row(input stim_t s, input exp_t e);
    rows_s.push_back(s);
    rows_e.push_back(e);
  endtask

  task automatic clear_rows();
    rows_s.delete();
    rows_e.delete();
  endtask

  task automatic do_reset();
    drive(NOP());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t got, want;
    rst_n = 1'b0;
    drive(ADD(5, 1, 2));
    #3;
    want = '0; got = obs_now(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_async: observed %h, expected %h", got, want);
    end
    drive(S(1, 4, 1, 4, 1, 9, 1, 0, 1));
    @(posedge clk); #1;
    got = obs_now(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_held_with_branch: observed %h, expected %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, want;
    do_reset(); clear_rows();
`ifdef HAZARD_FWD_EN
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(6, 5, 3), E(0, 0, 0, 0, 0, 0));
    row(NOP(),        E(2, 0, 0, 0, 0, 0));
`else
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(6, 5, 3), E(0, 0, 1, 1, 0, 0));
    row(ADD(6, 5, 3), E(0, 0, 1, 1, 0, 1));
    row(ADD(6, 5, 3), E(0, 0, 0, 0, 0, 2));
    row(NOP(),        E(0, 0, 0, 0, 0, 2));
    row(NOP(),        E(0, 0, 0, 0, 0, 2));
`endif
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL back_to_back[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_distance2();
    exp_t got, want;
    do_reset(); clear_rows();
`ifdef HAZARD_FWD_EN
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(7, 3, 4), E(0, 0, 0, 0, 0, 0));
    row(ADD(8, 5, 7), E(0, 0, 0, 0, 0, 0));
    row(NOP(),        E(1, 2, 0, 0, 0, 0));
`else
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(7, 3, 4), E(0, 0, 0, 0, 0, 0));
    row(ADD(8, 5, 7), E(0, 0, 1, 1, 0, 0));
    row(ADD(8, 5, 7), E(0, 0, 1, 1, 0, 1));
    row(ADD(8, 5, 7), E(0, 0, 0, 0, 0, 2));
    row(NOP(),        E(0, 0, 0, 0, 0, 2));
`endif
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL fwd_distance2[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_priority();
    exp_t got, want;
    do_reset(); clear_rows();
`ifdef HAZARD_FWD_EN
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(5, 3, 4), E(0, 0, 0, 0, 0, 0));
    row(ADD(9, 5, 6), E(0, 0, 0, 0, 0, 0));
    row(NOP(),        E(2, 0, 0, 0, 0, 0));
`else
    row(ADD(5, 1, 2), E(0, 0, 0, 0, 0, 0));
    row(ADD(5, 3, 4), E(0, 0, 0, 0, 0, 0));
    row(ADD(9, 5, 6), E(0, 0, 1, 1, 0, 0));
    row(ADD(9, 5, 6), E(0, 0, 1, 1, 0, 1));
    row(ADD(9, 5, 6), E(0, 0, 0, 0, 0, 2));
    row(NOP(),        E(0, 0, 0, 0, 0, 2));
`endif
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL fwd_priority[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t got, want;
    do_reset(); clear_rows();
`ifdef HAZARD_FWD_EN
    row(LW(4, 1),     E(0, 0, 0, 0, 0, 0));
    row(ADD(9, 4, 4), E(0, 0, 1, 1, 0, 0));
    row(ADD(9, 4, 4), E(0, 0, 0, 0, 0, 1));
    row(NOP(),        E(1, 1, 0, 0, 0, 1));
`else
    row(LW(4, 1),     E(0, 0, 0, 0, 0, 0));
    row(ADD(9, 4, 4), E(0, 0, 1, 1, 0, 0));
    row(ADD(9, 4, 4), E(0, 0, 1, 1, 0, 1));
    row(ADD(9, 4, 4), E(0, 0, 0, 0, 0, 2));
    row(NOP(),        E(0, 0, 0, 0, 0, 2));
`endif
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_unused();
    exp_t got, want;
    do_reset(); clear_rows();
    row(S(1, 1, 1, 0, 0, 0, 1, 0, 0), E(0, 0, 0, 0, 0, 0));  // addi x0,x1
    row(ADD(10, 0, 0),                E(0, 0, 0, 0, 0, 0));  // reads x0
    row(LW(4, 1),                     E(0, 0, 0, 0, 0, 0));
    row(S(1, 4, 0, 4, 0, 4, 1, 0, 0), E(0, 0, 0, 0, 0, 0));  // lui x4, fields alias x4
    row(NOP(),                        E(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL x0_unused[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_vs_stall();
    exp_t got, want;
    do_reset(); clear_rows();
    row(LW(4, 1),                     E(0, 0, 0, 0, 0, 0));
    row(S(1, 4, 1, 4, 1, 9, 1, 0, 1), E(0, 0, 0, 1, 1, 0));
    row(ADD(11, 9, 9),                E(0, 0, 0, 0, 0, 0));
    row(NOP(),                        E(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < rows_s.size(); i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL flush_vs_stall[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstall();
    exp_t got, want;
    int   last;
    do_reset(); clear_rows();
`ifdef HAZARD_FWD_EN
    row(LW(4, 1), E(0, 0, 0, 0, 0, 0));
    row(LW(4, 4), E(0, 0, 1, 1, 0, 0));
    row(LW(4, 4), E(0, 0, 0, 0, 0, 1));
    row(LW(4, 4), E(1, 0, 1, 1, 0, 1));
`else
    row(LW(4, 1), E(0, 0, 0, 0, 0, 0));
    row(LW(4, 4), E(0, 0, 1, 1, 0, 0));
    row(LW(4, 4), E(0, 0, 1, 1, 0, 1));
    row(LW(4, 4), E(0, 0, 0, 0, 0, 2));
    row(LW(4, 4), E(0, 0, 1, 1, 0, 2));
`endif
    last = rows_s.size() - 1;
    for (int i = 0; i < last; i++) begin
      drive(rows_s[i]); sb.push_back(rows_e[i]);
      @(negedge clk);
      got = obs_now(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_midstall[%0d]: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(rows_s[last]); sb.push_back(rows_e[last]);
    @(negedge clk);
    got = obs_now(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_midstall[stalling]: observed %h, expected %h", got, want);
    end
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(E(0, 0, 0, 0, 0, 0));
    got = obs_now(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_midstall[async]: observed %h, expected %h", got, want);
    end
    drive(NOP());
    @(posedge clk); #1;
    sb.push_back(E(0, 0, 0, 0, 0, 0));
    got = obs_now(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_midstall[held]: observed %h, expected %h", got, want);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive(LW(4, 4)); sb.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs_now(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_midstall[released]: observed %h, expected %h", got, want);
    end
    @(posedge clk); #1;
  endtask

  // Holding lw x4,0(x4) in ID produces a stall on a fixed cadence:
  // every other cycle with forwarding, two of every three without it.
  task automatic test_saturation();
    int         nst;
    logic       es;
    logic [2:0] ec;
    logic [5:0] got6, want6;
    do_reset();
    nst = 0;
    drive(LW(4, 4));
    for (int k = 0; k < 30; k++) begin
      es = FWD ? (k % 2 == 1) : (k % 3 != 0);
      ec = (nst >= 7) ? 3'd7 : 3'(nst);
      sat_q.push_back({es, es, es, ec});
      @(negedge clk);
      got6 = {s_si, s_sd, s_bx, s_cnt}; want6 = sat_q.pop_front(); n_checks++;
      if (got6 !== want6) begin
        n_fail++; $display("FAIL saturation[%0d]: observed si/sd/bx/cnt=%b, expected %b", k, got6, want6);
      end
      if (es) nst++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (s_cnt !== 3'd7) begin
      n_fail++; $display("FAIL saturation_final: observed %0d, expected 7", s_cnt);
    end
    n_checks++;
    if (stall_count !== 16'(nst)) begin
      n_fail++; $display("FAIL wide_count: observed %0d, expected %0d", stall_count, nst);
    end
    drive(NOP());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_fwd_distance2();
    test_fwd_priority();
    test_load_use();
    test_x0_unused();
    test_flush_vs_stall();
    test_reset_midstall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
